modexp_sequencer: RTL and testbench

- Square-and-multiply controller that computes result = base^exponent mod modulus.
- Acts as the initiator for the team's bit-serial interleaved modular multiplier (r = a*b mod n). It issues a load pulse, presents stable operands, waits for the multiplier's sticky ready, and consumes the product.
- Sits between the RSA top-level key/message registers and the multiplier. It does no arithmetic itself beyond bit selection and muxing.

---
 rtl/modexp_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_modexp_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/modexp_sequencer.sv
// modexp_sequencer: square-and-multiply controller computing base^exponent mod modulus
// by driving an external bit-serial modular multiplier (r = a*b mod n).
// Optional build macro: MODEXP_SKIP_LEADING_ZEROS_EN -- starts the scan at the
// highest set exponent bit (one extra LOAD cycle) instead of squaring 1 through
// all leading zeros.
module modexp_sequencer #(
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  output logic [WIDTH-1:0] mul_n,
  input  logic             mul_ready,
  input  logic [WIDTH-1:0] mul_result
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_SQ_ISSUE,
    S_SQ_GUARD,
    S_SQ_WAIT,
    S_MUL_ISSUE,
    S_MUL_GUARD,
    S_MUL_WAIT,
    S_NEXT,
    S_FINISH
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   base_q, base_d;
  logic [WIDTH-1:0]   exp_q, exp_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               mul_start_q, mul_start_d;
  logic [WIDTH-1:0]   mul_a_q, mul_a_d;
  logic [WIDTH-1:0]   mul_b_q, mul_b_d;
  logic [WIDTH-1:0]   mul_n_q, mul_n_d;

`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
  logic [IDX_W-1:0]   msb_idx_c;

  // Priority encoder: position of the highest set bit of the latched exponent
  always_comb begin
    msb_idx_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (exp_q[i]) msb_idx_c = IDX_W'(i);
    end
  end
`endif

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    exp_d       = exp_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    mul_start_d = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_n_d     = mul_n_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base;
          exp_d   = exponent;
          mul_n_d = modulus;
          busy_d  = 1'b1;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
          state_d = S_LOAD;
`else
          acc_d   = WIDTH'(1);
          idx_d   = IDX_W'(WIDTH - 1);
          state_d = S_SQ_ISSUE;
`endif
        end
      end

      S_LOAD: begin
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
        // The top set bit is consumed by seeding acc with the base itself
        if (exp_q == '0) begin
          acc_d   = WIDTH'(1);
          state_d = S_FINISH;
        end else begin
          acc_d   = base_q;
          idx_d   = msb_idx_c;
          state_d = S_NEXT;
        end
`else
        state_d = S_IDLE;
`endif
      end

      S_SQ_ISSUE:  state_d = S_SQ_GUARD;
      // Stale ready from the previous product is still visible here
      S_SQ_GUARD:  state_d = S_SQ_WAIT;

      S_SQ_WAIT: begin
        if (mul_ready) begin
          acc_d   = mul_result;
          state_d = exp_q[idx_q] ? S_MUL_ISSUE : S_NEXT;
        end
      end

      S_MUL_ISSUE: state_d = S_MUL_GUARD;
      S_MUL_GUARD: state_d = S_MUL_WAIT;

      S_MUL_WAIT: begin
        if (mul_ready) begin
          acc_d   = mul_result;
          state_d = S_NEXT;
        end
      end

      S_NEXT: begin
        if (idx_q == '0) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q - IDX_W'(1);
          state_d = S_SQ_ISSUE;
        end
      end

      S_FINISH: begin
        result_d = acc_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Operands are loaded alongside the pulse and then held until the product returns
    if (state_d == S_SQ_ISSUE) begin
      mul_start_d = 1'b1;
      mul_a_d     = acc_d;
      mul_b_d     = acc_d;
    end else if (state_d == S_MUL_ISSUE) begin
      mul_start_d = 1'b1;
      mul_a_d     = acc_d;
      mul_b_d     = base_d;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      exp_q       <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_n_q     <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      exp_q       <= exp_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      mul_start_q <= mul_start_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_n_q     <= mul_n_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_n     = mul_n_q;

endmodule

// File: tb/tb_modexp_sequencer.sv
// Directed bench for modexp_sequencer with a behavioural multiplier whose ready
// is sticky and clears one edge after mul_start, with configurable latency.
module tb_modexp_sequencer;

  localparam int unsigned W = 128;

`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
  localparam int P13 = 5;
  localparam int P10 = 4;
  localparam int P1  = 0;
  localparam int P0  = 0;
`else
  localparam int P13 = 131;
  localparam int P10 = 130;
  localparam int P1  = 129;
  localparam int P0  = 128;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] base_i, exp_i, mod_i;
  logic         busy, done;
  logic [W-1:0] result;
  logic         mul_start;
  logic [W-1:0] mul_a, mul_b, mul_n;
  logic         mul_ready;
  logic [W-1:0] mul_result;

  int n_checks = 0;
  int n_fail   = 0;

  modexp_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base       (base_i),
    .exponent   (exp_i),
    .modulus    (mod_i),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_n      (mul_n),
    .mul_ready  (mul_ready),
    .mul_result (mul_result)
  );

  always #5 clk = ~clk;

  // Multiplier model
  int unsigned  lat_lo = 2;
  int unsigned  lat_hi = 4;
  int unsigned  m_cnt;
  logic         m_busy;
  logic [W-1:0] lat_a, lat_b, lat_n;
  int           pulse_cnt = 0;
  int           stab_err  = 0;
  int           early_err = 0;

  function automatic logic [W-1:0] modmul(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] n);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    if (n == '0) return '0;
    return W'(p % {{W{1'b0}}, n});
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_busy     <= 1'b0;
      mul_ready  <= 1'b0;
      mul_result <= '0;
      m_cnt      <= 0;
    end else if (mul_start) begin
      if (m_busy) early_err <= early_err + 1;
      pulse_cnt <= pulse_cnt + 1;
      lat_a     <= mul_a;
      lat_b     <= mul_b;
      lat_n     <= mul_n;
      m_cnt     <= $urandom_range(lat_hi, lat_lo);
      m_busy    <= 1'b1;
    end else if (m_busy) begin
      if (m_cnt <= 1) begin
        mul_ready  <= 1'b1;
        mul_result <= modmul(lat_a, lat_b, lat_n);
        m_busy     <= 1'b0;
      end else begin
        mul_ready <= 1'b0;
        m_cnt     <= m_cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && m_busy && ({mul_a, mul_b, mul_n} !== {lat_a, lat_b, lat_n}))
      stab_err <= stab_err + 1;
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic launch(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] n);
    base_i = b;
    exp_i  = e;
    mod_i  = n;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic wait_done(output logic ok, output int cyc);
    cyc = 0;
    while (!done && cyc < 60000) begin
      @(posedge clk); #1;
      cyc++;
    end
    ok = done;
  endtask

  logic ok;
  int   cyc;
  int   p0;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    base_i = '0; exp_i = '0; mod_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",      W'(busy),      W'(0));
    check("rst_done",      W'(done),      W'(0));
    check("rst_result",    result,        W'(0));
    check("rst_mul_start", W'(mul_start), W'(0));
    check("rst_mul_a",     mul_a,         W'(0));
    check("rst_mul_b",     mul_b,         W'(0));
    check("rst_mul_n",     mul_n,         W'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // 4^13 mod 497
    p0 = pulse_cnt;
    launch(W'(4), W'(13), W'(497));
    check("t1_busy_after_start", W'(busy), W'(1));
    wait_done(ok, cyc);
    check("t1_done",   W'(ok),   W'(1));
    check("t1_busy_at_done", W'(busy), W'(0));
    check("t1_result", result,   W'(445));
    check("t1_pulses", W'(pulse_cnt - p0), W'(P13));
    @(posedge clk); #1;
    check("t1_done_one_cycle", W'(done), W'(0));
    check("t1_result_held", result, W'(445));

    // 2^10 mod 1000
    p0 = pulse_cnt;
    launch(W'(2), W'(10), W'(1000));
    wait_done(ok, cyc);
    check("t2_done",   W'(ok), W'(1));
    check("t2_result", result, W'(24));
    check("t2_pulses", W'(pulse_cnt - p0), W'(P10));

    // Long random latency with stale ready from previous product
    lat_lo = 10; lat_hi = 300;
    p0 = pulse_cnt;
    launch(W'(4), W'(13), W'(497));
    wait_done(ok, cyc);
    check("t3_done",   W'(ok), W'(1));
    check("t3_result", result, W'(445));
    check("t3_pulses", W'(pulse_cnt - p0), W'(P13));
    lat_lo = 2; lat_hi = 4;

    // 123^1 mod 1000
    p0 = pulse_cnt;
    launch(W'(123), W'(1), W'(1000));
    wait_done(ok, cyc);
    check("t4_done",   W'(ok), W'(1));
    check("t4_result", result, W'(123));
    check("t4_pulses", W'(pulse_cnt - p0), W'(P1));

    // exponent = 0
    p0 = pulse_cnt;
    launch(W'(7), W'(0), W'(11));
    wait_done(ok, cyc);
    check("t5_done",   W'(ok), W'(1));
    check("t5_result", result, W'(1));
    check("t5_pulses", W'(pulse_cnt - p0), W'(P0));
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    check("t5_fast_done", W'(cyc <= 2), W'(1));
`endif

    // base = 0
    launch(W'(0), W'(5), W'(9));
    wait_done(ok, cyc);
    check("t6_done",   W'(ok), W'(1));
    check("t6_result", result, W'(0));

    // start while busy is ignored: 10^3 mod 17 = 14
    launch(W'(10), W'(3), W'(17));
    repeat (20) @(posedge clk);
    #1;
    launch(W'(2), W'(10), W'(1000));
    wait_done(ok, cyc);
    check("t7_done",   W'(ok), W'(1));
    check("t7_result", result, W'(14));
    check("t7_mul_n",  mul_n,  W'(17));
    // next start accepted: 5^3 mod 13 = 8
    launch(W'(5), W'(3), W'(13));
    wait_done(ok, cyc);
    check("t7b_done",   W'(ok), W'(1));
    check("t7b_result", result, W'(8));

    // reset while waiting on the multiplier
    lat_lo = 10; lat_hi = 20;
    p0 = pulse_cnt;
    launch(W'(4), W'(13), W'(497));
    cyc = 0;
    while (pulse_cnt == p0 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("t8_first_pulse_seen", W'(pulse_cnt != p0), W'(1));
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t8_rst_busy",      W'(busy),      W'(0));
    check("t8_rst_result",    result,        W'(0));
    check("t8_rst_done",      W'(done),      W'(0));
    check("t8_rst_mul_start", W'(mul_start), W'(0));
    lat_lo = 2; lat_hi = 4;
    launch(W'(3), W'(5), W'(7));
    wait_done(ok, cyc);
    check("t8_done",   W'(ok), W'(1));
    check("t8_result", result, W'(5));

    @(posedge clk); #1;
    check("operand_stability_errors", W'(stab_err),  W'(0));
    check("early_consume_errors",     W'(early_err), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
